// File: rtl/trigger_multi.sv
// Actor trigger controller: launch / sleep / network-sync sequencing for one HLS actor.
// Optional execution statistics are built when TRIGGER_STATS_EN is defined.
module trigger_multi #(
  parameter int unsigned         NUM_EXT        = 1,
  parameter logic [NUM_EXT-1:0]  EXT_MASK       = '1,
  parameter int unsigned         TEST_RETRY_MAX = 8,
  parameter int unsigned         SLEEP_TIMEOUT  = 0,
  parameter int unsigned         CNT_W          = 32
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  input  logic               ap_start,
  output logic               ap_done,
  output logic               ap_ready,
  output logic               ap_idle,
  input  logic [NUM_EXT-1:0] external_enqueue,
  input  logic               all_sync,
  input  logic               all_sync_wait,
  input  logic               all_sleep,
  input  logic               all_waited,
  output logic               sleep,
  output logic               sync_exec,
  output logic               sync_wait,
  output logic               waited,
  input  logic [1:0]         actor_return,
  input  logic               actor_done,
  input  logic               actor_ready,
  input  logic               actor_idle,
  output logic               actor_start,
  output logic [CNT_W-1:0]   exec_count,
  output logic [CNT_W-1:0]   wait_count
);

  localparam int unsigned TC_W = $clog2(TEST_RETRY_MAX) + 1;
  localparam int unsigned SC_W = 32;
  localparam logic [1:0] RET_WAIT = 2'd0;
  localparam logic [1:0] RET_EXEC = 2'd1;
  localparam logic [1:0] RET_IDLE = 2'd2;
  localparam logic [1:0] RET_TEST = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_CHECK, S_SLEEP,
    S_SYNC_LAUNCH, S_SYNC_CHECK, S_SYNC_WAIT, S_SYNC_EXEC
  } state_t;

  state_t            state_q, state_d;
  logic [TC_W-1:0]   test_cnt_q, test_cnt_d;
  logic [SC_W-1:0]   sleep_cnt_q, sleep_cnt_d;
  logic              waited_q, waited_d;
  logic              actor_start_q, actor_start_d;
  logic              sleep_q, sleep_d;
  logic              sync_exec_q, sync_exec_d;
  logic              sync_wait_q, sync_wait_d;
  logic              ap_idle_q, ap_idle_d;
  logic              ap_done_q, ap_done_d;

  logic ext_hit, ret_exec, ret_wait, test_ok, eff_test, sleep_tmo;
  logic unused_handshake;

  assign ext_hit   = |(external_enqueue & EXT_MASK);
  assign ret_exec  = (actor_return == RET_EXEC);
  assign ret_wait  = (actor_return == RET_WAIT) || (actor_return == RET_IDLE);
  assign test_ok   = (test_cnt_q < TC_W'(TEST_RETRY_MAX - 1));
  assign eff_test  = (actor_return == RET_TEST) && test_ok;
  assign sleep_tmo = (SLEEP_TIMEOUT > 0) && (sleep_cnt_q == SC_W'(SLEEP_TIMEOUT - 1));
  assign unused_handshake = &{actor_ready, actor_idle};

  // Next-state, retry/sleep counters and registered-output decode.
  always_comb begin
    state_d     = state_q;
    test_cnt_d  = test_cnt_q;
    waited_d    = waited_q;
    sleep_cnt_d = (state_q == S_SLEEP) ? sleep_cnt_q + SC_W'(1) : '0;

    if (actor_done) begin
      waited_d = ret_wait;
      if (actor_return == RET_TEST) begin
        if (test_ok) test_cnt_d = test_cnt_q + TC_W'(1);
      end else begin
        test_cnt_d = '0;
      end
    end

    unique case (state_q)
      S_IDLE: if (ap_start) state_d = S_LAUNCH;
      S_LAUNCH, S_CHECK: begin
        if (!actor_done)                        state_d = S_CHECK;
        else if (ret_exec || eff_test || ext_hit) state_d = S_LAUNCH;
        else                                    state_d = S_SLEEP;
      end
      S_SLEEP: begin
        if (all_sleep)       state_d = S_SYNC_LAUNCH;
        else if (!all_waited) state_d = S_LAUNCH;
        else if (sleep_tmo)   state_d = S_LAUNCH;
      end
      S_SYNC_LAUNCH, S_SYNC_CHECK: begin
        if (!actor_done)   state_d = S_SYNC_CHECK;
        else if (ret_exec) state_d = S_SYNC_EXEC;
        else if (eff_test) state_d = S_SYNC_LAUNCH;
        else               state_d = S_SYNC_WAIT;
      end
      S_SYNC_WAIT: if (all_sync) state_d = all_sync_wait ? S_IDLE : S_LAUNCH;
      S_SYNC_EXEC: if (all_sync) state_d = S_LAUNCH;
      default:     state_d = S_IDLE;
    endcase

    actor_start_d = (state_d == S_LAUNCH) || (state_d == S_SYNC_LAUNCH);
    sleep_d       = (state_d == S_SLEEP);
    sync_exec_d   = (state_d == S_SYNC_EXEC);
    sync_wait_d   = (state_d == S_SYNC_WAIT) || (state_d == S_IDLE);
    ap_idle_d     = (state_d == S_IDLE);
    ap_done_d     = (state_q == S_SYNC_WAIT) && (state_d == S_IDLE);
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q       <= S_IDLE;
      test_cnt_q    <= '0;
      sleep_cnt_q   <= '0;
      waited_q      <= 1'b0;
      actor_start_q <= 1'b0;
      sleep_q       <= 1'b0;
      sync_exec_q   <= 1'b0;
      sync_wait_q   <= 1'b1;
      ap_idle_q     <= 1'b1;
      ap_done_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      test_cnt_q    <= test_cnt_d;
      sleep_cnt_q   <= sleep_cnt_d;
      waited_q      <= waited_d;
      actor_start_q <= actor_start_d;
      sleep_q       <= sleep_d;
      sync_exec_q   <= sync_exec_d;
      sync_wait_q   <= sync_wait_d;
      ap_idle_q     <= ap_idle_d;
      ap_done_q     <= ap_done_d;
    end
  end

  assign actor_start = actor_start_q;
  assign sleep       = sleep_q;
  assign sync_exec   = sync_exec_q;
  assign sync_wait   = sync_wait_q;
  assign waited      = waited_q;
  assign ap_idle     = ap_idle_q;
  assign ap_done     = ap_done_q;
  assign ap_ready    = ap_done_q;

`ifdef TRIGGER_STATS_EN
  logic [CNT_W-1:0] exec_cnt_q, exec_cnt_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  // Saturating return-code counters; a new start clears them.
  always_comb begin
    exec_cnt_d = exec_cnt_q;
    wait_cnt_d = wait_cnt_q;
    if ((state_q == S_IDLE) && ap_start) begin
      exec_cnt_d = '0;
      wait_cnt_d = '0;
    end else if (actor_done) begin
      if (ret_exec && (exec_cnt_q != '1)) exec_cnt_d = exec_cnt_q + CNT_W'(1);
      if (ret_wait && (wait_cnt_q != '1)) wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      exec_cnt_q <= '0;
      wait_cnt_q <= '0;
    end else begin
      exec_cnt_q <= exec_cnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign exec_count = exec_cnt_q;
  assign wait_count = wait_cnt_q;
`else
  assign exec_count = '0;
  assign wait_count = '0;
`endif

endmodule

// File: tb/tb_trigger_multi.sv
// Directed bench for trigger_multi: per-cycle vector table plus timeout, stats and reset sequences.
module tb_trigger_multi;

  logic       ap_clk = 1'b0;
  logic       ap_rst, ap_start;
  logic [1:0] external_enqueue;
  logic       all_sync, all_sync_wait, all_sleep, all_waited;
  logic [1:0] actor_return;
  logic       actor_done;

  logic        a_done, a_ready, a_idle, a_sleep, a_sexec, a_swait, a_waited, a_start;
  logic [31:0] a_exec_cnt, a_wait_cnt;
  logic        b_done, b_ready, b_idle, b_sleep, b_sexec, b_swait, b_waited, b_start;
  logic [31:0] b_exec_cnt, b_wait_cnt;

  int total = 0;
  int bad   = 0;

  always #5 ap_clk = ~ap_clk;

  trigger_multi #(.NUM_EXT(2), .EXT_MASK(2'b01), .TEST_RETRY_MAX(3), .SLEEP_TIMEOUT(4), .CNT_W(32)) dut_a (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start), .ap_done(a_done), .ap_ready(a_ready),
    .ap_idle(a_idle), .external_enqueue(external_enqueue), .all_sync(all_sync),
    .all_sync_wait(all_sync_wait), .all_sleep(all_sleep), .all_waited(all_waited),
    .sleep(a_sleep), .sync_exec(a_sexec), .sync_wait(a_swait), .waited(a_waited),
    .actor_return(actor_return), .actor_done(actor_done), .actor_ready(1'b0), .actor_idle(1'b0),
    .actor_start(a_start), .exec_count(a_exec_cnt), .wait_count(a_wait_cnt));

  trigger_multi #(.NUM_EXT(2), .EXT_MASK(2'b01), .TEST_RETRY_MAX(3), .SLEEP_TIMEOUT(0), .CNT_W(32)) dut_b (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start), .ap_done(b_done), .ap_ready(b_ready),
    .ap_idle(b_idle), .external_enqueue(external_enqueue), .all_sync(all_sync),
    .all_sync_wait(all_sync_wait), .all_sleep(all_sleep), .all_waited(all_waited),
    .sleep(b_sleep), .sync_exec(b_sexec), .sync_wait(b_swait), .waited(b_waited),
    .actor_return(actor_return), .actor_done(actor_done), .actor_ready(1'b0), .actor_idle(1'b0),
    .actor_start(b_start), .exec_count(b_exec_cnt), .wait_count(b_wait_cnt));

  // exp = {actor_start, sleep, sync_exec, sync_wait, ap_idle, ap_done, waited} after the edge
  typedef struct {
    logic       start;
    logic       done;
    logic [1:0] ret;
    logic [1:0] ext;
    logic       asl;
    logic       aw;
    logic       asy;
    logic       asw;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic s, logic d, logic [1:0] r, logic [1:0] e,
                              logic sl, logic w, logic sy, logic sw, logic [6:0] x);
    vec_t v;
    v.start = s; v.done = d; v.ret = r; v.ext = e;
    v.asl = sl; v.aw = w; v.asy = sy; v.asw = sw; v.exp = x;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    ap_start = v.start; actor_done = v.done; actor_return = v.ret; external_enqueue = v.ext;
    all_sleep = v.asl; all_waited = v.aw; all_sync = v.asy; all_sync_wait = v.asw;
  endtask

  task automatic idle_in();
    drive(mk(0, 0, 2'd0, 2'b00, 0, 1, 0, 0, 7'd0));
  endtask

  task automatic do_reset();
    idle_in();
    ap_rst = 1'b1;
    step();
    step();
    ap_rst = 1'b0;
  endtask

  function automatic logic [6:0] outs_a();
    return {a_start, a_sleep, a_sexec, a_swait, a_idle, a_done, a_waited};
  endfunction

  logic [31:0] exp_exec, exp_wait;

  initial begin
    // cycle-by-cycle vectors
    vecs.push_back(mk(1, 0, 2'd0, 2'b00, 0, 1, 0, 0, 7'b1000000)); // start -> LAUNCH
    vecs.push_back(mk(0, 0, 2'd0, 2'b00, 0, 1, 0, 0, 7'b0000000)); // CHECK
    vecs.push_back(mk(0, 1, 2'd1, 2'b00, 0, 1, 0, 0, 7'b1000000)); // EXEC relaunch
    vecs.push_back(mk(0, 0, 2'd0, 2'b00, 0, 1, 0, 0, 7'b0000000));
    vecs.push_back(mk(0, 1, 2'd1, 2'b00, 0, 1, 0, 0, 7'b1000000)); // EXEC relaunch
    vecs.push_back(mk(0, 1, 2'd0, 2'b10, 0, 1, 0, 0, 7'b0100001)); // masked ext -> SLEEP
    vecs.push_back(mk(0, 0, 2'd0, 2'b00, 0, 0, 0, 0, 7'b1000001)); // !all_waited -> LAUNCH
    vecs.push_back(mk(0, 1, 2'd0, 2'b01, 0, 1, 0, 0, 7'b1000001)); // unmasked ext -> LAUNCH
    vecs.push_back(mk(0, 1, 2'd3, 2'b00, 0, 1, 0, 0, 7'b1000000)); // TEST 1
    vecs.push_back(mk(0, 1, 2'd3, 2'b00, 0, 1, 0, 0, 7'b1000000)); // TEST 2
    vecs.push_back(mk(0, 1, 2'd3, 2'b00, 0, 1, 0, 0, 7'b0100000)); // TEST 3 -> SLEEP
    vecs.push_back(mk(0, 0, 2'd0, 2'b00, 1, 1, 0, 0, 7'b1000000)); // all_sleep -> SYNC_LAUNCH
    vecs.push_back(mk(0, 0, 2'd0, 2'b00, 0, 1, 0, 0, 7'b0000000)); // SYNC_CHECK
    vecs.push_back(mk(0, 1, 2'd1, 2'b00, 0, 1, 0, 0, 7'b0010000)); // EXEC -> SYNC_EXEC
    vecs.push_back(mk(0, 0, 2'd0, 2'b00, 0, 1, 0, 0, 7'b0010000)); // hold
    vecs.push_back(mk(0, 0, 2'd0, 2'b00, 0, 1, 1, 0, 7'b1000000)); // all_sync -> LAUNCH
    vecs.push_back(mk(0, 1, 2'd0, 2'b00, 0, 1, 0, 0, 7'b0100001)); // WAIT -> SLEEP
    vecs.push_back(mk(0, 0, 2'd0, 2'b00, 1, 1, 0, 0, 7'b1000001));
    vecs.push_back(mk(0, 1, 2'd3, 2'b00, 0, 1, 0, 0, 7'b1000000)); // eff TEST -> SYNC_LAUNCH
    vecs.push_back(mk(0, 1, 2'd0, 2'b00, 0, 1, 0, 0, 7'b0001001)); // WAIT -> SYNC_WAIT
    vecs.push_back(mk(0, 0, 2'd0, 2'b00, 0, 1, 1, 0, 7'b1000001)); // sync, no sync_wait -> LAUNCH
    vecs.push_back(mk(0, 1, 2'd0, 2'b00, 0, 1, 0, 0, 7'b0100001));
    vecs.push_back(mk(0, 0, 2'd0, 2'b00, 1, 1, 0, 0, 7'b1000001));
    vecs.push_back(mk(0, 1, 2'd2, 2'b00, 0, 1, 0, 0, 7'b0001001)); // IDLE ret -> SYNC_WAIT
    vecs.push_back(mk(0, 0, 2'd0, 2'b00, 0, 1, 1, 1, 7'b0001111)); // -> IDLE, ap_done
    vecs.push_back(mk(0, 0, 2'd0, 2'b00, 0, 1, 0, 0, 7'b0001101)); // parked, no done
    vecs.push_back(mk(1, 0, 2'd0, 2'b00, 0, 1, 0, 0, 7'b1000001)); // start
    vecs.push_back(mk(0, 1, 2'd0, 2'b00, 0, 1, 0, 0, 7'b0100001));
    vecs.push_back(mk(0, 1, 2'd1, 2'b00, 0, 1, 0, 0, 7'b0100000)); // done ignored in SLEEP
    vecs.push_back(mk(0, 0, 2'd0, 2'b00, 0, 0, 0, 0, 7'b1000000));
    vecs.push_back(mk(0, 1, 2'd0, 2'b00, 0, 1, 0, 0, 7'b0100001));
    vecs.push_back(mk(0, 0, 2'd0, 2'b00, 1, 1, 0, 0, 7'b1000001));
    vecs.push_back(mk(0, 1, 2'd0, 2'b00, 0, 1, 0, 0, 7'b0001001));
    vecs.push_back(mk(1, 0, 2'd0, 2'b00, 0, 1, 1, 1, 7'b0001111)); // start in SYNC_WAIT ignored
    vecs.push_back(mk(1, 0, 2'd0, 2'b00, 0, 1, 0, 0, 7'b1000001)); // start during ap_done

    ap_rst = 1'b0;
    do_reset();
    chk("reset_outs", 64'(outs_a()), 64'(7'b0001100));
    chk("reset_ready", 64'(a_ready), 64'd0);
    chk("reset_cnt", 64'({a_exec_cnt, a_wait_cnt}), 64'd0);

    foreach (vecs[i]) begin
      drive(vecs[i]);
      step();
      chk($sformatf("vec%0d", i), 64'(outs_a()), 64'(vecs[i].exp));
      chk($sformatf("vec%0d_ready", i), 64'(a_ready), 64'(vecs[i].exp[1]));
    end

    // SLEEP timeout: dut_a relaunches 4 cycles after entry, dut_b stays asleep
    do_reset();
    drive(mk(1, 0, 2'd0, 2'b00, 0, 1, 0, 0, 7'd0));
    step();
    drive(mk(0, 1, 2'd0, 2'b00, 0, 1, 0, 0, 7'd0));
    step();
    idle_in();
    chk("tmo_entry", 64'({a_sleep, b_sleep}), 64'(2'b11));
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("tmo_wait%0d", k), 64'({a_sleep, a_start}), 64'(2'b10));
    end
    step();
    chk("tmo_relaunch", 64'({a_sleep, a_start}), 64'(2'b01));
    chk("tmo0_hold", 64'({b_sleep, b_start}), 64'(2'b10));
    for (int k = 0; k < 20; k++) step();
    chk("tmo0_long", 64'({b_sleep, b_start}), 64'(2'b10));

    // stats: 5 EXEC + 3 WAIT (kept awake by ext), then reset in CHECK
    do_reset();
    drive(mk(1, 0, 2'd0, 2'b00, 0, 1, 0, 0, 7'd0));
    step();
    for (int k = 0; k < 5; k++) begin
      drive(mk(0, 1, 2'd1, 2'b00, 0, 1, 0, 0, 7'd0));
      step();
    end
    for (int k = 0; k < 3; k++) begin
      drive(mk(0, 1, 2'd0, 2'b01, 0, 1, 0, 0, 7'd0));
      step();
    end
    idle_in();
    step();
    chk("in_check", 64'({a_start, a_sleep, a_idle}), 64'd0);
`ifdef TRIGGER_STATS_EN
    exp_exec = 32'd5;
    exp_wait = 32'd3;
`else
    exp_exec = 32'd0;
    exp_wait = 32'd0;
`endif
    chk("exec_count", 64'(a_exec_cnt), 64'(exp_exec));
    chk("wait_count", 64'(a_wait_cnt), 64'(exp_wait));
    ap_rst = 1'b1;
    step();
    ap_rst = 1'b0;
    chk("rst_mid_outs", 64'(outs_a()), 64'(7'b0001100));
    chk("rst_mid_cnt", 64'({a_exec_cnt, a_wait_cnt}), 64'd0);
    step();
    chk("rst_mid_nodone", 64'({a_done, a_ready, a_start}), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
